fetch_line_ctrl: RTL
====================

Name: fetch_line_ctrl

Overview:
- Instruction-fetch line controller; sits directly downstream of presence_check and consumes its here/will_be_here flags.
- Holds the single current i-cache line buffer and its tag, and feeds line_pc/line_valid/prev_pc back to presence_check.
- Issues line requests to the i-cache on a miss and serves one instruction per cycle to decode over a valid/ready handshake.

Parameters:
- XLEN, 32, address width (matches mmm_pkg).
- ILEN, 32, instruction width in bits.
- OFFSET, 2, byte-offset bits within an instruction.
- ICACHE_OFFSET, 2, instruction-index bits within a line; LINE_W = ILEN*2**ICACHE_OFFSET.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- flush_i  in  1  invalidate line buffer (fence.i / redirect to unknown state).
- pc_i  in  XLEN  fetch PC from PC generator.
- pc_valid_i  in  1  pc_i is a live fetch request.
- here_i  in  1  from presence_check: line buffer holds pc_i's line.
- will_be_here_i  in  1  from presence_check: pc_i's line is the one last requested.
- instr_o  out  ILEN  selected instruction word.
- instr_valid_o  out  1  instr_o valid.
- instr_ready_i  in  1  decode accepts instr_o.
- line_pc_o  out  XLEN  address of buffered line (to presence_check line_pc_i).
- line_valid_o  out  1  buffer valid (to presence_check line_valid_i).
- prev_pc_o  out  XLEN  address of last issued line request (to presence_check prev_pc_i).
- icache_req_valid_o  out  1  line request valid.
- icache_req_ready_i  in  1  i-cache accepts request.
- icache_req_addr_o  out  XLEN  line-aligned request address, low ICACHE_OFFSET+OFFSET bits zero.
- icache_resp_valid_i  in  1  line returned; one-cycle pulse, no backpressure.
- icache_resp_line_i  in  LINE_W  returned line; word k at bits [k*ILEN +: ILEN].

Behaviour:
- Reset values: state IDLE; line_valid_o=0; line_pc_o=0; prev_pc_o=0; icache_req_valid_o=0; instr_valid_o=0; instr_o=0.
- FSM states: IDLE, REQ, WAIT, DRAIN. At most one outstanding request.
- Hit path, any state:
  - instr_valid_o = pc_valid_i & here_i & !flush_i, combinational, zero latency.
  - instr_o = buffer word at pc_i[ICACHE_OFFSET+OFFSET-1:OFFSET].
  - instr_o = 0 when instr_valid_o=0.
  - On valid & !ready, instr_o stays stable as long as pc_i is stable.
- IDLE:
  - pc_valid_i & !here_i & !flush_i -> REQ; latch req addr = pc_i with low bits cleared.
  - will_be_here_i is ignored in IDLE (nothing outstanding), so a stale prev_pc_o match is treated as a miss.
- REQ:
  - icache_req_valid_o=1; address held stable until handshake.
  - On icache_req_ready_i: prev_pc_o <= request address; next state WAIT (or DRAIN if flush_i is high or was seen while in REQ).
  - Valid is never withdrawn before the handshake.
- WAIT:
  - On icache_resp_valid_i: buffer <= icache_resp_line_i, line_pc_o <= prev_pc_o, line_valid_o <= 1, next state IDLE.
  - A hit is visible to presence_check the cycle after the response.
  - will_be_here_i=1 in WAIT suppresses any new request; the controller stalls until the response.
- DRAIN: discard the next icache_resp_valid_i (no buffer write, line_valid_o stays 0), then go to IDLE.
- flush_i:
  - Clears line_valid_o next cycle in every state.
  - IDLE: stays in IDLE.
  - REQ: sets a pending-drain flag.
  - WAIT: goes to DRAIN.
  - Flush and response in the same WAIT cycle: response is discarded, go to IDLE (not DRAIN).
- Miss resolution: miss -> REQ -> WAIT -> IDLE. Minimum miss penalty is 3 cycles (ready=1 in REQ, response in the first WAIT cycle).
- Synchronous rst_i mid-operation (REQ/WAIT) returns everything to reset values.
  - An in-flight response arriving after reset, while in IDLE, is ignored.
  - The i-cache must be reset together with this block.

Optional Feature:
- FETCH_PERF_CNT_EN
- Defined: adds outputs hit_cnt_o and miss_cnt_o (32 bits each), reset to 0, saturating at 2^32-1.
  - hit_cnt_o increments on each instr_valid_o & instr_ready_i.
  - miss_cnt_o increments on each IDLE->REQ transition.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then pc_valid_i=1, pc_i=0x100, here_i=0 -> icache_req_valid_o=1, addr=0x100; ready next cycle; response with line {0x4,0x3,0x2,0x1} -> next cycle line_valid_o=1, line_pc_o=0x100.
- With line 0x100 valid, pc_i=0x108, here_i=1, instr_ready_i=0 for 2 cycles -> instr_valid_o=1, instr_o=0x3 held stable; accepted on cycle 3.
- Miss at 0x200 with icache_req_ready_i low for 3 cycles -> req_valid_o and addr=0x200 held stable for 4 cycles; prev_pc_o=0x200 after handshake.
- In WAIT, pc_i=0x204 with will_be_here_i=1 -> no second request; response fills the line, 0x204 then hits.
- flush_i in WAIT, response 2 cycles later -> state DRAIN, buffer not written, line_valid_o=0; next miss issues a fresh request.
- flush_i and icache_resp_valid_i in the same cycle -> line discarded, line_valid_o=0, state IDLE, no DRAIN.

Source files
------------

// File: rtl/fetch_line_ctrl_if.sv
// Fetch line controller bus bundle: PC/presence inputs, decode handshake,
// presence_check feedback and the i-cache request/response channel.
// master = the fetch line controller, slave = its surroundings.
interface fetch_line_ctrl_if #(
    parameter int XLEN          = 32,
    parameter int ILEN          = 32,
    parameter int ICACHE_OFFSET = 2
);
    localparam int LINE_W = ILEN * (2 ** ICACHE_OFFSET);

    logic              flush_i;
    logic [XLEN-1:0]   pc_i;
    logic              pc_valid_i;
    logic              here_i;
    logic              will_be_here_i;
    logic [ILEN-1:0]   instr_o;
    logic              instr_valid_o;
    logic              instr_ready_i;
    logic [XLEN-1:0]   line_pc_o;
    logic              line_valid_o;
    logic [XLEN-1:0]   prev_pc_o;
    logic              icache_req_valid_o;
    logic              icache_req_ready_i;
    logic [XLEN-1:0]   icache_req_addr_o;
    logic              icache_resp_valid_i;
    logic [LINE_W-1:0] icache_resp_line_i;

    modport master (
        input  flush_i, pc_i, pc_valid_i, here_i, will_be_here_i, instr_ready_i,
               icache_req_ready_i, icache_resp_valid_i, icache_resp_line_i,
        output instr_o, instr_valid_o, line_pc_o, line_valid_o, prev_pc_o,
               icache_req_valid_o, icache_req_addr_o
    );

    modport slave (
        output flush_i, pc_i, pc_valid_i, here_i, will_be_here_i, instr_ready_i,
               icache_req_ready_i, icache_resp_valid_i, icache_resp_line_i,
        input  instr_o, instr_valid_o, line_pc_o, line_valid_o, prev_pc_o,
               icache_req_valid_o, icache_req_addr_o
    );
endinterface

// File: rtl/fetch_line_ctrl.sv
// Instruction-fetch line controller: one buffered i-cache line, single
// outstanding line request, zero-latency hit path to decode.
// Optional macro FETCH_PERF_CNT_EN adds saturating hit/miss counters.
module fetch_line_ctrl #(
    parameter int XLEN          = 32,
    parameter int ILEN          = 32,
    parameter int OFFSET        = 2,
    parameter int ICACHE_OFFSET = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fetch_line_ctrl_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o
`endif
);
    localparam int WORDS = 2 ** ICACHE_OFFSET;
    localparam int LOW   = ICACHE_OFFSET + OFFSET;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t                      state;
    logic [WORDS-1:0][ILEN-1:0]  line_buf;
    logic [XLEN-1:0]             line_pc;
    logic                        line_valid;
    logic [XLEN-1:0]             prev_pc;
    logic                        req_valid;
    logic [XLEN-1:0]             req_addr;
    logic                        drain_pend;

    logic [ICACHE_OFFSET-1:0]    word_sel;
    logic                        hit;
    logic                        miss;

    assign word_sel = bus.pc_i[LOW-1:OFFSET];
    assign hit      = bus.pc_valid_i & bus.here_i & ~bus.flush_i;
    assign miss     = bus.pc_valid_i & ~bus.here_i & ~bus.flush_i;

    // Hit path is purely combinational so a buffered line costs no cycles;
    // instr_o is a function of pc_i and the buffer, so it holds while pc_i holds.
    assign bus.instr_valid_o      = hit;
    assign bus.instr_o            = hit ? line_buf[word_sel] : '0;
    assign bus.line_pc_o          = line_pc;
    assign bus.line_valid_o       = line_valid;
    assign bus.prev_pc_o          = prev_pc;
    assign bus.icache_req_valid_o = req_valid;
    assign bus.icache_req_addr_o  = req_addr;

    // A new request is only ever issued from IDLE, so will_be_here_i stalling
    // in WAIT falls out of the state machine; the byte offset never matters.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bus.will_be_here_i, bus.instr_ready_i,
                             bus.pc_i[OFFSET-1:0]};

    // Request/response state machine; flush always drops the buffered line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            line_pc    <= '0;
            line_valid <= 1'b0;
            prev_pc    <= '0;
            req_valid  <= 1'b0;
            req_addr   <= '0;
            drain_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Responses seen here are stale (e.g. across a reset) and dropped.
                    if (miss) begin
                        req_addr   <= {bus.pc_i[XLEN-1:LOW], {LOW{1'b0}}};
                        req_valid  <= 1'b1;
                        drain_pend <= 1'b0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (bus.flush_i) drain_pend <= 1'b1;
                    if (bus.icache_req_ready_i) begin
                        prev_pc   <= req_addr;
                        req_valid <= 1'b0;
                        state     <= (bus.flush_i | drain_pend) ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.icache_resp_valid_i) begin
                        // A flush landing with the response kills it outright.
                        if (!bus.flush_i) begin
                            line_buf   <= bus.icache_resp_line_i;
                            line_pc    <= prev_pc;
                            line_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (bus.flush_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.icache_resp_valid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (bus.flush_i) line_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating hit (accepted instruction) and miss (new request) counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (hit && bus.instr_ready_i && hit_cnt_o != '1)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (state == IDLE && miss && miss_cnt_o != '1)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule
